// File: rtl/line_raster_engine.sv
// Midpoint (Bresenham) line rasteriser: endpoints in, one frame-buffer write per pixel out.
// Define LINE_RASTER_CLIP_EN to suppress writes outside H_RES x V_RES.
module line_raster_engine #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 8,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               draw_start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] color,
    input  logic               fb_ready,
    output logic               busy,
    output logic               draw_done,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic [COLOR_W-1:0] draw_data,
    output logic               draw_we
);
    localparam int EW = COORD_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic [COLOR_W-1:0] color_q;

    logic signed [EW-1:0] dx, dy, err, err_nxt;
    logic signed [EW-1:0] ddx, ddy, adx, ady;
    logic signed [EW:0]   e2, dx_e, dy_e;
    logic                 sx_neg, sy_neg;
    logic                 step_x, step_y;
    logic                 at_end, pix_on, advance;

    assign ddx = $signed({2'b00, x1_q}) - $signed({2'b00, x0_q});
    assign ddy = $signed({2'b00, y1_q}) - $signed({2'b00, y0_q});
    assign adx = ddx[EW-1] ? -ddx : ddx;
    assign ady = ddy[EW-1] ? -ddy : ddy;

    // One extra bit keeps 2*err exact
    assign e2   = {err, 1'b0};
    assign dx_e = {dx[EW-1], dx};
    assign dy_e = {dy[EW-1], dy};

    assign step_x = (e2 >= dy_e);
    assign step_y = (e2 <= dx_e);

    always_comb begin
        err_nxt = err;
        if (step_x) err_nxt = err_nxt + dy;
        if (step_y) err_nxt = err_nxt + dx;
    end

    assign at_end = (cur_x == x1_q) && (cur_y == y1_q);

`ifdef LINE_RASTER_CLIP_EN
    assign pix_on = (32'(cur_x) < 32'(H_RES)) && (32'(cur_y) < 32'(V_RES));
`else
    logic clip_unused;
    assign clip_unused = ^{32'(H_RES), 32'(V_RES)};
    assign pix_on      = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        draw_done = 1'b0;
        draw_we   = 1'b0;
        advance   = 1'b0;
        unique case (state)
            IDLE: begin
                if (draw_start) state_nxt = SETUP;
            end
            SETUP: begin
                busy      = 1'b1;
                state_nxt = DRAW;
            end
            DRAW: begin
                busy    = 1'b1;
                draw_we = pix_on;
                // Clipped pixels step without waiting on the frame buffer
                advance = fb_ready || !pix_on;
                if (advance && at_end) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                draw_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            dx      <= '0;
            dy      <= '0;
            err     <= '0;
            sx_neg  <= 1'b0;
            sy_neg  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (draw_start) begin
                        x0_q    <= x0;
                        y0_q    <= y0;
                        x1_q    <= x1;
                        y1_q    <= y1;
                        color_q <= color;
                    end
                end
                SETUP: begin
                    dx     <= adx;
                    dy     <= -ady;
                    err    <= adx - ady;
                    sx_neg <= !(x0_q < x1_q);
                    sy_neg <= !(y0_q < y1_q);
                    cur_x  <= x0_q;
                    cur_y  <= y0_q;
                end
                DRAW: begin
                    if (advance && !at_end) begin
                        err <= err_nxt;
                        if (step_x)
                            cur_x <= sx_neg ? cur_x - COORD_W'(1)
                                            : cur_x + COORD_W'(1);
                        if (step_y)
                            cur_y <= sy_neg ? cur_y - COORD_W'(1)
                                            : cur_y + COORD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign DrawX     = cur_x;
    assign DrawY     = cur_y;
    assign draw_data = color_q;

endmodule
